// File: rtl/nn_pkg.sv
// Shared fixed-point types and the sigmoid table contents used by the NN blocks.
package nn_pkg;

  localparam int unsigned DATA_WIDTH         = 16;
  localparam int unsigned FRAC_BITS          = 8;
  localparam int unsigned SIGMOID_ADDR_WIDTH = 10;
  localparam int unsigned SIGMOID_LUT_SIZE   = 1 << SIGMOID_ADDR_WIDTH;

  typedef logic signed [DATA_WIDTH-1:0]  fixed_t;
  typedef logic [SIGMOID_ADDR_WIDTH-1:0] lut_addr_t;

  typedef struct packed {
    logic      sat;
    lut_addr_t addr;
  } lut_map_t;

  // Table entry a holds sigmoid((a - SIZE/2) / 64) in Q8.8, using a
  // piecewise-linear fit on |z| mirrored as 1 - y for negative z.
  function automatic fixed_t sigmoid_rom(input lut_addr_t a);
    lut_addr_t             mid;
    lut_addr_t             u;
    logic [DATA_WIDTH-1:0] y;
    mid = lut_addr_t'(SIGMOID_LUT_SIZE / 2);
    u   = a[SIGMOID_ADDR_WIDTH-1] ? (a - mid) : (mid - a);
    if (u < lut_addr_t'(64)) begin
      y = DATA_WIDTH'(u) + DATA_WIDTH'(128);
    end else if (u < lut_addr_t'(152)) begin
      y = DATA_WIDTH'(u >> 1) + DATA_WIDTH'(160);
    end else if (u < lut_addr_t'(320)) begin
      y = DATA_WIDTH'(u >> 3) + DATA_WIDTH'(216);
    end else begin
      y = DATA_WIDTH'(256);
    end
    if (!a[SIGMOID_ADDR_WIDTH-1]) begin
      y = DATA_WIDTH'(256) - y;
    end
    return fixed_t'(y);
  endfunction

endpackage

// File: rtl/sigmoid_lut.sv
// Dual-port sigmoid table with one-cycle registered read per port.
module sigmoid_lut
  import nn_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en_a,
  input  logic [SIGMOID_ADDR_WIDTH-1:0] addr_a,
  output logic [DATA_WIDTH-1:0]         dout_a,
  input  logic                          en_b,
  input  logic [SIGMOID_ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0]         dout_b
);

  logic [DATA_WIDTH-1:0] dout_a_q;
  logic [DATA_WIDTH-1:0] dout_b_q;

  // Only the read registers are cleared; the table itself is constant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else begin
      if (en_a) dout_a_q <= sigmoid_rom(addr_a);
      if (en_b) dout_b_q <= sigmoid_rom(addr_b);
    end
  end

  assign dout_a = dout_a_q;
  assign dout_b = dout_b_q;

endmodule

// File: rtl/sigmoid_arbiter.sv
// Two-grant round-robin arbiter sharing one dual-port sigmoid LUT among
// NUM_REQ requesters; fixed two-cycle latency, no back-pressure.
module sigmoid_arbiter
  import nn_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] resp_data,
  output logic [15:0]                   sat_count
);

  localparam logic signed [DATA_WIDTH:0] IDX_MID = (DATA_WIDTH+1)'(SIGMOID_LUT_SIZE / 2);
  localparam logic signed [DATA_WIDTH:0] IDX_MAX = (DATA_WIDTH+1)'(SIGMOID_LUT_SIZE - 1);

  logic [ID_W-1:0]               ptr_q, ptr_d;
  logic [ID_W-1:0]               scan_idx;
  logic                          en_a, en_b;
  logic [ID_W-1:0]               id_a, id_b;
  lut_map_t                      map_a, map_b;
  logic [1:0]                    sat_inc;
  logic [16:0]                   sat_sum;
  logic [15:0]                   sat_count_q, sat_count_d;

  logic                          s1_vld_a_q, s1_vld_b_q;
  logic [ID_W-1:0]               s1_id_a_q, s1_id_b_q;
  logic [SIGMOID_ADDR_WIDTH-1:0] s1_addr_a_q, s1_addr_b_q;
  logic                          s2_vld_a_q, s2_vld_b_q;
  logic [ID_W-1:0]               s2_id_a_q, s2_id_b_q;
  logic [DATA_WIDTH-1:0]         lut_dout_a, lut_dout_b;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (32'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
  endfunction

  function automatic lut_map_t map_addr(input logic [DATA_WIDTH-1:0] x);
    logic signed [DATA_WIDTH:0] ext;
    logic signed [DATA_WIDTH:0] idx;
    lut_map_t                   m;
    ext    = {x[DATA_WIDTH-1], x};
    ext    = ext >>> (FRAC_BITS - 6);
    idx    = ext + IDX_MID;
    m.sat  = idx[DATA_WIDTH] || (idx > IDX_MAX);
    if (idx[DATA_WIDTH])    m.addr = '0;
    else if (idx > IDX_MAX) m.addr = '1;
    else                    m.addr = idx[SIGMOID_ADDR_WIDTH-1:0];
    return m;
  endfunction

  // Port A takes the first requester at/after the pointer, port B the second.
  always_comb begin
    en_a     = 1'b0;
    en_b     = 1'b0;
    id_a     = '0;
    id_b     = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!rst && req_valid[scan_idx]) begin
        if (!en_a) begin
          en_a = 1'b1;
          id_a = scan_idx;
        end else if (!en_b) begin
          en_b = 1'b1;
          id_b = scan_idx;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (en_a) req_ready[id_a] = 1'b1;
    if (en_b) req_ready[id_b] = 1'b1;
  end

  always_comb begin
    if (en_b)      ptr_d = next_id(id_b);
    else if (en_a) ptr_d = next_id(id_a);
    else           ptr_d = ptr_q;
  end

  assign map_a = map_addr(req_data[32'(id_a)*DATA_WIDTH +: DATA_WIDTH]);
  assign map_b = map_addr(req_data[32'(id_b)*DATA_WIDTH +: DATA_WIDTH]);

  assign sat_inc     = {1'b0, en_a & map_a.sat} + {1'b0, en_b & map_b.sat};
  assign sat_sum     = {1'b0, sat_count_q} + 17'(sat_inc);
  assign sat_count_d = sat_sum[16] ? '1 : sat_sum[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      sat_count_q <= '0;
      s1_vld_a_q  <= 1'b0;
      s1_vld_b_q  <= 1'b0;
      s2_vld_a_q  <= 1'b0;
      s2_vld_b_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      sat_count_q <= sat_count_d;
      s1_vld_a_q  <= en_a;
      s1_vld_b_q  <= en_b;
      s2_vld_a_q  <= s1_vld_a_q;
      s2_vld_b_q  <= s1_vld_b_q;
    end
  end

  always_ff @(posedge clk) begin
    s1_id_a_q   <= id_a;
    s1_id_b_q   <= id_b;
    s1_addr_a_q <= map_a.addr;
    s1_addr_b_q <= map_b.addr;
    s2_id_a_q   <= s1_id_a_q;
    s2_id_b_q   <= s1_id_b_q;
  end

  sigmoid_lut u_lut (
    .clk    (clk),
    .rst_n  (~rst),
    .en_a   (s1_vld_a_q),
    .addr_a (s1_addr_a_q),
    .dout_a (lut_dout_a),
    .en_b   (s1_vld_b_q),
    .addr_b (s1_addr_b_q),
    .dout_b (lut_dout_b)
  );

  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    if (s2_vld_a_q) begin
      resp_valid[s2_id_a_q] = 1'b1;
      resp_data[32'(s2_id_a_q)*DATA_WIDTH +: DATA_WIDTH] = lut_dout_a;
    end
    if (s2_vld_b_q) begin
      resp_valid[s2_id_b_q] = 1'b1;
      resp_data[32'(s2_id_b_q)*DATA_WIDTH +: DATA_WIDTH] = lut_dout_b;
    end
  end

  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Bench for sigmoid_arbiter: directed vectors plus a per-cycle reference model.
module tb_sigmoid_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [N*DW-1:0] resp_data;
  logic [15:0]     sat_count;

  int checks   = 0;
  int failures = 0;

  sigmoid_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .sat_count  (sat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Unclamped table index for a Q8.8 input: floor(x*64) + 512.
  function automatic int idx_of(input logic [15:0] x);
    int xi;
    xi = int'($signed(x));
    return (xi >>> 2) + 512;
  endfunction

  function automatic logic [15:0] sig_val(input logic [15:0] x);
    int  idx;
    int  yp;
    real mag;
    real y;
    idx = idx_of(x);
    if (idx < 0)    idx = 0;
    if (idx > 1023) idx = 1023;
    mag = (idx - 512) / 64.0;
    if (mag < 0.0) mag = -mag;
    if (mag < 1.0)        y = 0.25 * mag + 0.5;
    else if (mag < 2.375) y = 0.125 * mag + 0.625;
    else if (mag < 5.0)   y = 0.03125 * mag + 0.84375;
    else                  y = 1.0;
    yp = int'($floor(y * 256.0));
    if (idx < 512) yp = 256 - yp;
    return 16'(yp);
  endfunction

  // Reference model: state as seen during the current cycle.
  bit          model_ok = 1'b0;
  int          p_m, sat_m, n_g, last_g, s_g, nsat;
  logic [N-1:0] g, cur_v, d1_v;
  logic [15:0]  cur_d [N];
  logic [15:0]  d1_d  [N];
  logic [N*DW-1:0] exp_rd;

  always @(negedge clk) begin
    g = '0; n_g = 0; last_g = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        s_g = (p_m + k) % N;
        if (req_valid[s_g] && n_g < 2) begin
          g[s_g] = 1'b1; n_g++; last_g = s_g;
        end
      end
    end
    if (model_ok) begin
      exp_rd = '0;
      for (int i = 0; i < N; i++) if (cur_v[i]) exp_rd[i*DW +: DW] = cur_d[i];
      check("cmp_ready", 64'(req_ready), 64'(g));
      check("cmp_resp_valid", 64'(resp_valid), 64'(cur_v));
      check("cmp_resp_data", resp_data, exp_rd);
      check("cmp_sat_count", 64'(sat_count), 64'(sat_m));
    end
    if (rst) begin
      p_m = 0; sat_m = 0; cur_v = '0; d1_v = '0; model_ok = 1'b1;
    end else begin
      cur_v = d1_v;
      cur_d = d1_d;
      d1_v  = g;
      nsat  = 0;
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          d1_d[i] = sig_val(req_data[i*DW +: DW]);
          if (idx_of(req_data[i*DW +: DW]) < 0 || idx_of(req_data[i*DW +: DW]) > 1023) nsat++;
        end
      end
      sat_m = (sat_m + nsat > 65535) ? 65535 : sat_m + nsat;
      if (last_g >= 0) p_m = (last_g + 1) % N;
    end
  end

  task automatic single(input int slot, input logic [15:0] x, input logic [15:0] exp_d, input int exp_sat);
    req_valid = '0;
    req_valid[slot] = 1'b1;
    req_data[slot*DW +: DW] = x;
    @(negedge clk);
    check("single_ready", 64'(req_ready), 64'(1 << slot));
    cyc();
    req_valid = '0;
    cyc();
    @(negedge clk);
    check("single_valid", 64'(resp_valid), 64'(1 << slot));
    check("single_data", 64'(resp_data[slot*DW +: DW]), 64'(exp_d));
    check("single_sat", 64'(sat_count), 64'(exp_sat));
    cyc();
  endtask

  logic [3:0] rr_pat [3] = '{4'b0011, 4'b1100, 4'b0011};
  logic [3:0] mix    [12] = '{4'b0111, 4'b0111, 4'b0111, 4'b0100, 4'b1001, 4'b1111,
                              4'b0000, 4'b0010, 4'b1110, 4'b1011, 4'b0101, 4'b1000};

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0;
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_sat", 64'(sat_count), 64'd0);
    cyc();

    single(0, 16'h0000, 16'h0080, 0);
    single(2, 16'h0100, 16'h00C0, 0);
    single(1, 16'hF800, 16'h0000, 0);
    single(3, 16'h0800, 16'h0100, 1);
    single(0, 16'h8000, 16'h0000, 2);

    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 16'(i * 64 + 16);
    for (int k = 0; k < 5; k++) begin
      req_valid = (k < 3) ? 4'hF : 4'h0;
      @(negedge clk);
      if (k < 3)  check("rr4_ready", 64'(req_ready), 64'(rr_pat[k]));
      if (k >= 2) check("rr4_resp", 64'(resp_valid), 64'(rr_pat[k-2]));
      cyc();
    end

    req_valid = 4'b1010;
    @(negedge clk); check("p2_ready", 64'(req_ready), 64'(4'b1010)); cyc();
    req_valid = 4'hF;
    @(negedge clk); check("p2_after", 64'(req_ready), 64'(4'b1100)); cyc();

    for (int k = 0; k < 12; k++) begin
      req_valid = mix[k];
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 16'(k * 16'h1357 + i * 16'h0BAD);
      cyc();
    end
    req_valid = '0; cyc(); cyc();

    req_valid = 4'b0100; req_data[2*DW +: DW] = 16'h0800;
    @(negedge clk); check("prerst_ready", 64'(req_ready), 64'(4'b0100)); cyc();
    rst = 1'b1; req_valid = 4'hF;
    @(negedge clk); check("rst_ready", 64'(req_ready), 64'd0); cyc();
    rst = 1'b0; req_valid = '0;
    @(negedge clk);
    check("rst_drop_valid", 64'(resp_valid), 64'd0);
    check("rst_drop_sat", 64'(sat_count), 64'd0);
    cyc();
    req_valid = 4'hF;
    @(negedge clk); check("rst_ptr0", 64'(req_ready), 64'(4'b0011)); cyc();
    req_valid = '0; repeat (3) cyc();

    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 16'h8000;
    req_valid = 4'hF;
    repeat (35000) cyc();
    req_valid = '0; cyc(); cyc();
    @(negedge clk);
    check("sat_hold", 64'(sat_count), 64'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
